udt_decode_p: RTL and testbench
===============================

UDT_DECODE_P -- requirements
Module: udt_decode_p

Interface
REQ-001 SHALL have parameter DATA_W, default 64, stream data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have ports clk in 1 (sole clock) and core_rst_n in 1 (reset; asynchronous, active-low).
REQ-004 SHALL have input stream ports in_tdata in DATA_W, in_tkeep in DATA_W/8, in_tvalid in 1, in_tready out 1, in_tlast in 1.
REQ-005 SHALL have payload stream ports out_tdata out DATA_W, out_tkeep out DATA_W/8, out_tvalid out 1, out_tready in 1, out_tlast out 1.
REQ-006 SHALL have type-pulse outputs Data_en, ACK_en, ACK2_en, Keep_live_en, NAK_en, Handshake_en, CLOSE_en and error, each out 1.
REQ-007 SHALL have hdr_w0 out 32 (header word 0) and hdr_w1 out 32 (header word 1), both valid while any type pulse is high.
REQ-008 SHALL have cnt_clr in 1 (synchronous clear of both counters), pkt_cnt out CNT_W (good packets) and err_cnt out CNT_W (errored packets).

Function
REQ-009 Byte order SHALL be big-endian: the first byte of a packet is in tdata[DATA_W-1 -: 8], and in_tkeep[DATA_W/8-1] qualifies that byte.
REQ-010 The UDT header SHALL be 16 bytes, carried in exactly HB = 128/DATA_W beats; no byte realignment is performed.
REQ-011 The FSM SHALL have three states. HDR: header collection, in_tready=1. PAY: payload forwarding. DROP: discard until in_tlast, in_tready=1.
REQ-012 Classification from header word 0 SHALL be as follows.
  - bit31=0 gives Data.
  - bit31=1 with bits[30:16] = 0/1/2/3/5/6 gives Handshake/Keep_live/ACK/NAK/CLOSE/ACK2 respectively.
  - Any other value gives error.
REQ-013 Exactly one type pulse (or error) SHALL be high for exactly one cycle per packet, in the cycle after the final header beat is accepted.
REQ-014 Error conditions SHALL be: in_tlast before the final header beat; in_tkeep not all-ones on any header beat; undefined control type; a Data packet with in_tlast on the final header beat (no payload).
REQ-015 On an error with in_tlast not yet seen, the FSM SHALL enter DROP; no out beats are produced for an errored packet.
REQ-016 A good packet with in_tlast on the final header beat (control only) SHALL return to HDR and produce no out beats.
REQ-017 In PAY, payload beats SHALL be forwarded unchanged (tdata, tkeep, tlast) through a one-entry register with 1-cycle latency, and in_tready = !out_tvalid | out_tready.
REQ-018 On acceptance of a payload beat with in_tlast=1, the FSM SHALL move to HDR; the next packet's header may be accepted while the last payload beat waits in the register.
REQ-019 out_tvalid, once high, SHALL hold with stable out_tdata/out_tkeep/out_tlast until out_tready=1.
REQ-020 pkt_cnt SHALL increment on each non-error type pulse and err_cnt on each error pulse; both saturate at all-ones.
REQ-021 If cnt_clr coincides with an increment, the clear SHALL win (result 0).

Reset
REQ-022 While core_rst_n=0, the FSM SHALL be HDR, and all outputs SHALL be 0 except in_tready, which is 1 once reset deasserts.
REQ-023 Reset mid-packet SHALL discard the partial packet and any held out beat; after release, the next beat is treated as header beat 0.

Structure
REQ-024 Package udt_pkg SHALL hold the control-type constants, the FSM state enum, a 128-bit header struct, and the legal-DATA_W check.
REQ-025 The output register SHALL be a sub-module udt_axis_reg (parametrised by DATA_W); the FSM, classification and counters SHALL live in udt_decode_p.

Verification
REQ-026 DATA_W=64, header 0x0000_0010/0x0000_0001/x/x plus 3 payload beats -> Data_en pulse, hdr_w0=0x10, 3 out beats 1 cycle later, pkt_cnt=1.
REQ-027 DATA_W=32, header 0x8002_0000 (4 beats) plus 1 payload beat tkeep=4'b1100 -> ACK_en pulse, out beat with tkeep 4'b1100 and tlast=1.
REQ-028 Control type 0x0004 -> error pulse, err_cnt=1, remaining beats dropped, zero out beats.
REQ-029 in_tlast on header beat 1 of 2 (DATA_W=64) -> error pulse; next packet decodes correctly.
REQ-030 out_tready toggled randomly across 100 packets at all three DATA_W values -> out stream equals input payload byte-exact, no loss or duplication.
REQ-031 core_rst_n pulsed low mid-payload -> outputs zero; a following Keep_live packet (0x8001_0000) yields Keep_live_en and pkt_cnt=1.

Source files
------------

// File: rtl/udt_pkg.sv
// rtl/udt_pkg.sv - UDT decoder control-type codes, FSM states, header layout and width check
package udt_pkg;

  localparam int HDR_BITS = 128;

  localparam logic [14:0] CT_HANDSHAKE = 15'd0;
  localparam logic [14:0] CT_KEEP_LIVE = 15'd1;
  localparam logic [14:0] CT_ACK       = 15'd2;
  localparam logic [14:0] CT_NAK       = 15'd3;
  localparam logic [14:0] CT_CLOSE     = 15'd5;
  localparam logic [14:0] CT_ACK2      = 15'd6;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PAY  = 2'd1,
    ST_DROP = 2'd2
  } udt_state_t;

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } udt_hdr_t;

  function automatic bit data_w_legal(input int w);
    return (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/udt_axis_reg.sv
// rtl/udt_axis_reg.sv - one-entry stream register with full-throughput ready
module udt_axis_reg #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [DATA_W/8-1:0] in_tkeep,
  input  logic                in_tvalid,
  output logic                in_tready,
  input  logic                in_tlast,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                out_tlast
);

  // The slot may be refilled in the same cycle its current beat leaves.
  assign in_tready = !out_tvalid || out_tready;

  // Load a new beat whenever the slot is free or draining; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
    end else if (in_tready) begin
      out_tvalid <= in_tvalid;
      if (in_tvalid) begin
        out_tdata <= in_tdata;
        out_tkeep <= in_tkeep;
        out_tlast <= in_tlast;
      end
    end
  end

endmodule

// File: rtl/udt_decode_p.sv
// rtl/udt_decode_p.sv - UDT header decoder: classifies packets, forwards payload, counts outcomes
module udt_decode_p
  import udt_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                core_rst_n,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [DATA_W/8-1:0] in_tkeep,
  input  logic                in_tvalid,
  output logic                in_tready,
  input  logic                in_tlast,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                out_tlast,
  output logic                Data_en,
  output logic                ACK_en,
  output logic                ACK2_en,
  output logic                Keep_live_en,
  output logic                NAK_en,
  output logic                Handshake_en,
  output logic                CLOSE_en,
  output logic                error,
  output logic [31:0]         hdr_w0,
  output logic [31:0]         hdr_w1,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int HB = HDR_BITS / DATA_W;

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("udt_decode_p: DATA_W must be 32, 64 or 128");
  end

  udt_state_t state, state_n;
  udt_hdr_t   hdr_q, hdr_n;
  logic [1:0] beat_cnt;
  logic       keep_err;
  logic       last_beat, undef_ctl, bad_hdr;
  logic [6:0] type_vec, type_n;
  logic       err_n, hdr_take, hdr_end;
  logic       reg_in_tvalid, reg_in_tready;

  assign last_beat = (beat_cnt == 2'(HB - 1));

  // Header as it will look once the current beat is written into its slot.
  always_comb begin
    hdr_n = hdr_q;
    hdr_n[HDR_BITS-1 - DATA_W*int'(beat_cnt) -: DATA_W] = in_tdata;
  end

  // Type decode of word 0; bit order {Data, ACK, ACK2, Keep_live, NAK, Handshake, CLOSE}.
  always_comb begin
    type_vec  = '0;
    undef_ctl = 1'b0;
    if (!hdr_n.w0[31]) begin
      type_vec[6] = 1'b1;
    end else begin
      case (hdr_n.w0[30:16])
        CT_ACK:       type_vec[5] = 1'b1;
        CT_ACK2:      type_vec[4] = 1'b1;
        CT_KEEP_LIVE: type_vec[3] = 1'b1;
        CT_NAK:       type_vec[2] = 1'b1;
        CT_HANDSHAKE: type_vec[1] = 1'b1;
        CT_CLOSE:     type_vec[0] = 1'b1;
        default:      undef_ctl   = 1'b1;
      endcase
    end
  end

  // A Data packet ending on its header has no payload and counts as malformed.
  assign bad_hdr = keep_err || !(&in_tkeep) || undef_ctl || (type_vec[6] && in_tlast);

  // FSM state register.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= ST_HDR;
    else             state <= state_n;
  end

  // Next state, handshakes and the pulse to raise next cycle.
  always_comb begin
    state_n       = state;
    in_tready     = 1'b0;
    reg_in_tvalid = 1'b0;
    hdr_take      = 1'b0;
    hdr_end       = 1'b0;
    type_n        = '0;
    err_n         = 1'b0;
    case (state)
      ST_HDR: begin
        in_tready = core_rst_n;
        if (in_tvalid && core_rst_n) begin
          hdr_take = 1'b1;
          if (last_beat) begin
            hdr_end = 1'b1;
            if (bad_hdr) begin
              err_n   = 1'b1;
              state_n = in_tlast ? ST_HDR : ST_DROP;
            end else begin
              type_n  = type_vec;
              state_n = in_tlast ? ST_HDR : ST_PAY;
            end
          end else if (in_tlast) begin
            hdr_end = 1'b1;
            err_n   = 1'b1;
          end
        end
      end
      ST_PAY: begin
        in_tready     = reg_in_tready;
        reg_in_tvalid = in_tvalid;
        if (in_tvalid && reg_in_tready && in_tlast) state_n = ST_HDR;
      end
      ST_DROP: begin
        in_tready = 1'b1;
        if (in_tvalid && in_tlast) state_n = ST_HDR;
      end
      default: state_n = ST_HDR;
    endcase
  end

  // Header capture, beat position, keep error tracking and registered type pulses.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      hdr_q    <= '0;
      beat_cnt <= '0;
      keep_err <= 1'b0;
      hdr_w0   <= '0;
      hdr_w1   <= '0;
      error    <= 1'b0;
      {Data_en, ACK_en, ACK2_en, Keep_live_en, NAK_en, Handshake_en, CLOSE_en} <= '0;
    end else begin
      {Data_en, ACK_en, ACK2_en, Keep_live_en, NAK_en, Handshake_en, CLOSE_en} <= type_n;
      error <= err_n;
      if (hdr_take) begin
        hdr_q <= hdr_n;
        if (hdr_end) begin
          beat_cnt <= '0;
          keep_err <= 1'b0;
          hdr_w0   <= hdr_n.w0;
          hdr_w1   <= hdr_n.w1;
        end else begin
          beat_cnt <= beat_cnt + 2'd1;
          keep_err <= keep_err || !(&in_tkeep);
        end
      end
    end
  end

  // Saturating outcome counters; a clear overrides any same-cycle increment.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if ((Data_en || ACK_en || ACK2_en || Keep_live_en || NAK_en || Handshake_en || CLOSE_en)
          && (pkt_cnt != '1))
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (error && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  udt_axis_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk        (clk),
    .rst_n      (core_rst_n),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tvalid  (reg_in_tvalid),
    .in_tready  (reg_in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast)
  );

endmodule

// File: tb/tb_udt_decode_p.sv
// tb/tb_udt_decode_p.sv - scoreboard bench for udt_decode_p at DATA_W 32, 64 and 128
`timescale 1ns/1ps
module tb_udt_decode_p;

  localparam int CW = 4;
  localparam logic [7:0] V_DATA  = 8'h80;
  localparam logic [7:0] V_ACK   = 8'h40;
  localparam logic [7:0] V_ACK2  = 8'h20;
  localparam logic [7:0] V_KL    = 8'h10;
  localparam logic [7:0] V_NAK   = 8'h08;
  localparam logic [7:0] V_HS    = 8'h04;
  localparam logic [7:0] V_CLOSE = 8'h02;
  localparam logic [7:0] V_ERR   = 8'h01;

  typedef struct { logic [127:0] d; logic [15:0] k; logic l; } beat_t;
  typedef struct { logic [7:0] v; logic [31:0] w0; logic [31:0] w1; logic chk; } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] classify(input logic [31:0] w0);
    if (!w0[31]) return V_DATA;
    case (w0[30:16])
      15'd0:   return V_HS;
      15'd1:   return V_KL;
      15'd2:   return V_ACK;
      15'd3:   return V_NAK;
      15'd5:   return V_CLOSE;
      15'd6:   return V_ACK2;
      default: return V_ERR;
    endcase
  endfunction

  function automatic logic [14:0] rnd_code(input int i);
    case (i)
      0: return 15'd0;
      1: return 15'd1;
      2: return 15'd2;
      3: return 15'd3;
      4: return 15'd5;
      5: return 15'd6;
      6: return 15'd4;
      default: return 15'd7;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int W  = 32 << g;
    localparam int KB = W / 8;
    localparam int HB = 128 / W;

    logic          rst_n;
    logic [W-1:0]  in_tdata;
    logic [KB-1:0] in_tkeep;
    logic          in_tvalid, in_tready, in_tlast;
    logic [W-1:0]  out_tdata;
    logic [KB-1:0] out_tkeep;
    logic          out_tvalid, out_tlast;
    logic          out_tready = 1'b1;
    logic          Data_en, ACK_en, ACK2_en, Keep_live_en, NAK_en, Handshake_en, CLOSE_en, error;
    logic [31:0]   hdr_w0, hdr_w1;
    logic          cnt_clr;
    logic [CW-1:0] pkt_cnt, err_cnt;
    logic [7:0]    pv;

    beat_t  exp_beats[$];
    pulse_t exp_pulses[$];
    int     rdy_mode = 2;
    logic   gaps = 1'b0;

    assign pv = {Data_en, ACK_en, ACK2_en, Keep_live_en, NAK_en, Handshake_en, CLOSE_en, error};

    udt_decode_p #(.DATA_W(W), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .core_rst_n   (rst_n),
      .in_tdata     (in_tdata),
      .in_tkeep     (in_tkeep),
      .in_tvalid    (in_tvalid),
      .in_tready    (in_tready),
      .in_tlast     (in_tlast),
      .out_tdata    (out_tdata),
      .out_tkeep    (out_tkeep),
      .out_tvalid   (out_tvalid),
      .out_tready   (out_tready),
      .out_tlast    (out_tlast),
      .Data_en      (Data_en),
      .ACK_en       (ACK_en),
      .ACK2_en      (ACK2_en),
      .Keep_live_en (Keep_live_en),
      .NAK_en       (NAK_en),
      .Handshake_en (Handshake_en),
      .CLOSE_en     (CLOSE_en),
      .error        (error),
      .hdr_w0       (hdr_w0),
      .hdr_w1       (hdr_w1),
      .cnt_clr      (cnt_clr),
      .pkt_cnt      (pkt_cnt),
      .err_cnt      (err_cnt)
    );

    function automatic string tg(input string s);
      return $sformatf("w%0d_%s", W, s);
    endfunction

    always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_tready = 1'($urandom_range(0, 1));
        1:       out_tready = 1'b0;
        default: out_tready = 1'b1;
      endcase
    end

    initial begin
      logic   hold;
      beat_t  held, b;
      pulse_t p;
      hold = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (pv != 8'h0) begin
            if (exp_pulses.size() == 0) check(tg("unexp_pulse"), pv, 0);
            else begin
              p = exp_pulses.pop_front();
              check(tg("pulse"), pv, p.v);
              if (p.chk) check(tg("hdr_words"), {hdr_w0, hdr_w1}, {p.w0, p.w1});
            end
          end
          if (hold)
            check(tg("hold"), {out_tvalid, out_tlast, out_tkeep, out_tdata},
                  {1'b1, held.l, held.k[KB-1:0], held.d[W-1:0]});
          if (out_tvalid && out_tready) begin
            if (exp_beats.size() == 0) check(tg("unexp_beat"), out_tvalid, 0);
            else begin
              b = exp_beats.pop_front();
              check(tg("beat"), {out_tlast, out_tkeep, out_tdata}, {b.l, b.k[KB-1:0], b.d[W-1:0]});
            end
          end
          hold   = out_tvalid && !out_tready;
          held.d = 128'(out_tdata);
          held.k = 16'(out_tkeep);
          held.l = out_tlast;
        end else begin
          hold = 1'b0;
        end
      end
    end

    task automatic drive_beat(input logic [W-1:0] d, input logic [KB-1:0] k, input logic l);
      int guard;
      guard     = 0;
      in_tdata  = d;
      in_tkeep  = k;
      in_tlast  = l;
      in_tvalid = 1'b1;
      #1;
      while (!in_tready && guard < 500) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 500) check(tg("in_stall"), guard, 0);
      @(posedge clk);
      @(negedge clk);
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [127:0] hdr, input int npay, input int last_bytes,
                            input int tl_beat, input int bad_keep, input logic [7:0] ev);
      pulse_t        p;
      beat_t         b;
      logic [W-1:0]  d;
      logic [KB-1:0] ones, k;
      logic [127:0]  r;
      int            tb;
      ones = '1;
      tb   = (tl_beat >= 0) ? tl_beat : ((npay == 0) ? HB - 1 : -1);
      p.v   = ev;
      p.w0  = hdr[127:96];
      p.w1  = hdr[95:64];
      p.chk = !ev[0];
      exp_pulses.push_back(p);
      for (int i = 0; i < HB; i++) begin
        d = hdr[127 - i*W -: W];
        k = (i == bad_keep) ? (ones >> 1) : ones;
        drive_beat(d, k, i == tb);
        if (i == tb) break;
      end
      if (tb < 0) begin
        for (int j = 0; j < npay; j++) begin
          r = {$urandom(), $urandom(), $urandom(), $urandom()};
          d = r[W-1:0];
          k = (j == npay - 1) ? (ones << (KB - last_bytes)) : ones;
          if (!ev[0]) begin
            b.d = 128'(d);
            b.k = 16'(k);
            b.l = (j == npay - 1);
            exp_beats.push_back(b);
          end
          drive_beat(d, k, j == npay - 1);
        end
      end
    endtask

    task automatic wait_idle();
      int guard;
      guard = 0;
      while ((exp_beats.size() != 0 || exp_pulses.size() != 0) && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 3000) check(tg("drain"), guard, 0);
      @(negedge clk);
      @(negedge clk);
    endtask

    task automatic check_quiet(input string s);
      check(tg({s, "_ctl"}), {in_tready, out_tvalid, out_tlast, out_tkeep, pv, pkt_cnt, err_cnt}, 0);
      check(tg({s, "_hdr"}), {hdr_w0, hdr_w1}, 0);
      check(tg({s, "_data"}), out_tdata, 0);
    endtask

    initial begin
      int          goods, errs, sel, np;
      logic [31:0] w0;
      logic [7:0]  ev;
      rst_n     = 1'b0;
      in_tvalid = 1'b0;
      in_tdata  = '0;
      in_tkeep  = '0;
      in_tlast  = 1'b0;
      cnt_clr   = 1'b0;
      #2;
      check_quiet("reset");
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      #1 check(tg("ready_after_rst"), in_tready, 1);
      @(negedge clk);

      send_pkt({32'h0000_0010, 32'h0000_0001, 32'hdead_beef, 32'h1234_5678}, 3, KB, -1, -1, V_DATA);
      wait_idle();
      check(tg("cnt_data"), {pkt_cnt, err_cnt}, {4'd1, 4'd0});

      send_pkt({32'h8002_0000, 96'h0}, 1, KB / 2, -1, -1, V_ACK);
      wait_idle();
      check(tg("cnt_ack"), {pkt_cnt, err_cnt}, {4'd2, 4'd0});

      send_pkt({32'h8004_0000, 96'h0}, 2, KB, -1, -1, V_ERR);
      wait_idle();
      check(tg("cnt_undef"), {pkt_cnt, err_cnt}, {4'd2, 4'd1});

      send_pkt({32'h0000_0040, 32'h2, 64'h0}, 2, KB, 0, -1, V_ERR);
      send_pkt({32'h0000_0044, 32'h3, 64'h0}, 1, KB, -1, -1, V_DATA);
      wait_idle();
      check(tg("cnt_early_last"), {pkt_cnt, err_cnt}, {4'd3, 4'd2});

      send_pkt({32'h0000_0050, 96'h0}, 1, KB, -1, HB - 1, V_ERR);
      wait_idle();
      check(tg("cnt_keep_err"), {pkt_cnt, err_cnt}, {4'd3, 4'd3});

      send_pkt({32'h8000_0000, 96'h0}, 0, KB, -1, -1, V_HS);
      send_pkt({32'h8001_0000, 96'h0}, 0, KB, -1, -1, V_KL);
      send_pkt({32'h8003_0000, 96'h0}, 0, KB, -1, -1, V_NAK);
      send_pkt({32'h8005_0000, 96'h0}, 0, KB, -1, -1, V_CLOSE);
      send_pkt({32'h8006_0000, 96'h0}, 0, KB, -1, -1, V_ACK2);
      wait_idle();
      check(tg("cnt_ctl_only"), {pkt_cnt, err_cnt}, {4'd8, 4'd3});

      cnt_clr = 1'b1;
      send_pkt({32'h8001_0000, 96'h0}, 0, KB, -1, -1, V_KL);
      @(negedge clk);
      cnt_clr = 1'b0;
      #1 check(tg("clr_wins"), {pkt_cnt, err_cnt}, 0);
      wait_idle();

      rdy_mode = 0;
      gaps     = 1'b1;
      goods    = 0;
      errs     = 0;
      for (int n = 0; n < 100; n++) begin
        sel = $urandom_range(0, 8);
        if (sel == 0) begin
          w0 = {1'b0, 31'($urandom())};
          np = $urandom_range(1, 4);
        end else begin
          w0 = {1'b1, rnd_code(sel - 1), 16'($urandom())};
          np = $urandom_range(0, 2);
        end
        ev = classify(w0);
        if (ev[0]) errs++;
        else       goods++;
        send_pkt({w0, 32'($urandom()), 64'h0}, np, $urandom_range(1, KB), -1, -1, ev);
      end
      rdy_mode = 2;
      gaps     = 1'b0;
      wait_idle();
      check(tg("cnt_random_sat"), {pkt_cnt, err_cnt},
            {4'((goods > 15) ? 15 : goods), 4'((errs > 15) ? 15 : errs)});

      rdy_mode = 1;
      @(negedge clk);
      @(negedge clk);
      begin
        pulse_t p;
        p.v   = V_DATA;
        p.w0  = 32'h0000_0020;
        p.w1  = 32'h0000_0005;
        p.chk = 1'b1;
        exp_pulses.push_back(p);
      end
      for (int i = 0; i < HB; i++) begin
        logic [127:0] h;
        h = {32'h0000_0020, 32'h0000_0005, 64'h0};
        drive_beat(h[127 - i*W -: W], '1, 1'b0);
      end
      drive_beat(W'(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978), '1, 1'b0);
      #1 rst_n = 1'b0;
      #1 check_quiet("mid_rst");
      @(negedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 2;
      @(negedge clk);
      send_pkt({32'h8001_0000, 96'h0}, 0, KB, -1, -1, V_KL);
      wait_idle();
      check(tg("cnt_after_rst"), {pkt_cnt, err_cnt}, {4'd1, 4'd0});

      done_cnt++;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (done_cnt < 3 && guard < 80000) begin
      @(negedge clk);
      guard++;
    end
    check("lanes_done", done_cnt, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
